// File: rtl/camera_frame_seq_pkg.sv
// camera_frame_seq_pkg: shared camera types and default widths
//   cam_seq_state_t : frame sequencer states
//   DEF_*_W         : default widths for frame counter, frame limit, drop value, miss counter
package camera_frame_seq_pkg;
   localparam int DEF_FRAME_CNT_W = 16;
   localparam int DEF_NFRAMES_W   = 8;
   localparam int DEF_DROP_W      = 6;
   localparam int DEF_MISS_W      = 8;
   typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, SKIP} cam_seq_state_t;
endpackage

// File: rtl/camera_frame_seq_if.sv
// camera_frame_seq_if: config/sync inputs and frame status outputs of the sequencer
//   cfg_*      : start/stop pulses, frame drop and frame limit settings (master -> slave)
//   vsync_i    : polarity-corrected vsync, high = blanking (master -> slave)
//   ch_rdy_i   : RX buffer armed (master -> slave)
//   cap_en_o, frame_start_o, frame_done_o, busy_o, frame_cnt_o, miss_cnt_o : status (slave -> master)
interface camera_frame_seq_if
   import camera_frame_seq_pkg::*;
#(
   parameter int FRAME_CNT_W = DEF_FRAME_CNT_W,
   parameter int NFRAMES_W   = DEF_NFRAMES_W,
   parameter int DROP_W      = DEF_DROP_W,
   parameter int MISS_W      = DEF_MISS_W
) ();
   logic                   cfg_start_i;
   logic                   cfg_stop_i;
   logic                   cfg_framedrop_en_i;
   logic [DROP_W-1:0]      cfg_framedrop_val_i;
   logic [NFRAMES_W-1:0]   cfg_nframes_i;
   logic                   vsync_i;
   logic                   ch_rdy_i;
   logic                   cap_en_o;
   logic                   frame_start_o;
   logic                   frame_done_o;
   logic                   busy_o;
   logic [FRAME_CNT_W-1:0] frame_cnt_o;
   logic [MISS_W-1:0]      miss_cnt_o;
   modport master (
      output cfg_start_i, cfg_stop_i, cfg_framedrop_en_i, cfg_framedrop_val_i, cfg_nframes_i,
             vsync_i, ch_rdy_i,
      input  cap_en_o, frame_start_o, frame_done_o, busy_o, frame_cnt_o, miss_cnt_o
   );
   modport slave (
      input  cfg_start_i, cfg_stop_i, cfg_framedrop_en_i, cfg_framedrop_val_i, cfg_nframes_i,
             vsync_i, ch_rdy_i,
      output cap_en_o, frame_start_o, frame_done_o, busy_o, frame_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/camera_edge_det.sv
// camera_edge_det: registers a sync signal and flags its falling/rising edges
//   clk_i, rst_i : clock, async active-high reset
//   sig_i        : sync input
//   fall_o       : high in the cycle sig_i goes low
//   rise_o       : high in the cycle sig_i goes high
module camera_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic fall_o,
   output logic rise_o
);
   logic q;
   // Resets high so a signal already low at release is not seen as a new frame
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) q <= 1'b1;
      else       q <= sig_i;
   assign fall_o = q & ~sig_i;
   assign rise_o = ~q & sig_i;
endmodule

// File: rtl/camera_frame_seq.sv
// camera_frame_seq: frame-level capture sequencer (start/stop, frame drop, frame limit, miss count)
//   clk_i, rst_i : pixel clock, async active-high reset
//   bus          : config, vsync and channel-ready inputs; capture gate, frame pulses and counters
module camera_frame_seq
   import camera_frame_seq_pkg::*;
#(
   parameter int FRAME_CNT_W = DEF_FRAME_CNT_W,
   parameter int NFRAMES_W   = DEF_NFRAMES_W,
   parameter int DROP_W      = DEF_DROP_W,
   parameter int MISS_W      = DEF_MISS_W
) (
   input logic                clk_i,
   input logic                rst_i,
   camera_frame_seq_if.slave  bus
);
   cam_seq_state_t         state_q, state_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [MISS_W-1:0]      miss_q, miss_d;
   logic [DROP_W-1:0]      drop_q, drop_d;
   logic                   stop_pend_q, stop_pend_d;
   logic                   sof, eof, frame_start, frame_done;
   camera_edge_det u_vsync (.clk_i(clk_i), .rst_i(rst_i), .sig_i(bus.vsync_i), .fall_o(sof), .rise_o(eof));
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         miss_q      <= '0;
         drop_q      <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         miss_q      <= miss_d;
         drop_q      <= drop_d;
         stop_pend_q <= stop_pend_d;
      end
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      miss_d      = miss_q;
      drop_d      = drop_q;
      stop_pend_d = stop_pend_q;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      case (state_q)
         IDLE:
            if (bus.cfg_start_i && !bus.cfg_stop_i) begin
               state_d     = WAIT_SOF;
               frame_cnt_d = '0;
               miss_d      = '0;
               drop_d      = '0;
               stop_pend_d = 1'b0;
            end
         WAIT_SOF:
            // No frame in flight, so a stop here takes effect at once and masks a coincident sof
            if (bus.cfg_stop_i) state_d = IDLE;
            else if (sof) begin
               if (bus.cfg_framedrop_en_i && drop_q != '0) begin
                  state_d = SKIP;
                  drop_d  = drop_q - 1'b1;
               end else if (bus.ch_rdy_i) begin
                  state_d     = CAPTURE;
                  frame_start = 1'b1;
                  drop_d      = bus.cfg_framedrop_val_i;
               end else
                  miss_d = &miss_q ? miss_q : miss_q + 1'b1;
            end
         CAPTURE:
            if (eof) begin
               frame_done  = 1'b1;
               frame_cnt_d = frame_cnt_q + 1'b1;
               state_d     = (stop_pend_q || bus.cfg_stop_i ||
                              (bus.cfg_nframes_i != '0 && frame_cnt_d[NFRAMES_W-1:0] == bus.cfg_nframes_i))
                             ? IDLE : WAIT_SOF;
            end else if (bus.cfg_stop_i) stop_pend_d = 1'b1;
         SKIP:
            if (eof) state_d = (stop_pend_q || bus.cfg_stop_i) ? IDLE : WAIT_SOF;
            else if (bus.cfg_stop_i) stop_pend_d = 1'b1;
         default: state_d = IDLE;
      endcase
   end
   assign bus.cap_en_o      = state_q == CAPTURE;
   assign bus.busy_o        = state_q != IDLE;
   assign bus.frame_start_o = frame_start;
   assign bus.frame_done_o  = frame_done;
   assign bus.frame_cnt_o   = frame_cnt_q;
   assign bus.miss_cnt_o    = miss_q;
endmodule

// File: doc/camera_frame_seq.md
Name: camera_frame_seq

Overview:
Frame-level capture sequencer for the parallel camera interface, in the pixel-clock domain between the configuration register block and the pixel/window datapath. Arms on a software start pulse, aligns to frame boundaries from the polarity-corrected vsync, and applies frame dropping and frame-count limits. Gates the pixel datapath per frame and reports frame events and missed frames (no RX buffer armed) to the uDMA side.

Parameters:
FRAME_CNT_W, 16, width of captured-frame counter (wraps)
NFRAMES_W, 8, width of frame-limit field; value 0 = continuous
DROP_W, 6, width of framedrop value (frames skipped after each captured frame)
MISS_W, 8, width of missed-frame counter (saturating)

Ports:
clk_i  in  1  pixel-domain clock
rst_i  in  1  asynchronous reset, active-high
cfg_start_i  in  1  single-cycle start pulse (software enable write)
cfg_stop_i  in  1  single-cycle stop request
cfg_framedrop_en_i  in  1  enable frame dropping
cfg_framedrop_val_i  in  DROP_W  frames to skip after each captured frame
cfg_nframes_i  in  NFRAMES_W  frames to capture before auto-stop; 0 = continuous
vsync_i  in  1  polarity-corrected vsync, synchronous to clk_i; high = vertical blanking
ch_rdy_i  in  1  RX channel has a buffer armed (cfg_rx_en level from uDMA channel)
cap_en_o  out  1  gate for pixel/window datapath; high only during a captured frame
frame_start_o  out  1  one-cycle pulse at start of each captured frame
frame_done_o  out  1  one-cycle pulse at end of each captured frame
busy_o  out  1  sequencer not IDLE (readback as IP-enable status)
frame_cnt_o  out  FRAME_CNT_W  frames captured since last start
miss_cnt_o  out  MISS_W  frames lost because ch_rdy_i was low at SOF

Behaviour:
- Reset: all outputs 0; state IDLE; vsync_q=1 (no false edge on release); counters, drop_cnt, stop_pend = 0.
- Edges: vsync_q registers vsync_i. sof = vsync_q & ~vsync_i (falling); eof = ~vsync_q & vsync_i (rising). Zero-latency, combinational from registered history.
- States: IDLE, WAIT_SOF, CAPTURE, SKIP.
- IDLE: cfg_start_i -> WAIT_SOF; clears frame_cnt, miss_cnt, drop_cnt, stop_pend. Start and stop in the same cycle: stop wins, stay IDLE.
- WAIT_SOF on sof, priority order:
  1. framedrop_en & drop_cnt != 0 -> SKIP, drop_cnt--.
  2. Else ch_rdy_i -> CAPTURE, frame_start_o=1 that cycle, drop_cnt <= framedrop_val.
  3. Else miss_cnt++ (saturate at all-ones); stay in WAIT_SOF; drop_cnt unchanged.
- WAIT_SOF, cfg_stop_i -> IDLE the next cycle (no frame in flight).
- CAPTURE: cap_en_o=1 from the cycle after sof through the eof cycle inclusive. On eof: frame_done_o=1, frame_cnt++ (wraps).
  - If stop_pend | cfg_stop_i, or (cfg_nframes_i != 0 and new frame_cnt[NFRAMES_W-1:0] == cfg_nframes_i) -> IDLE.
  - Else -> WAIT_SOF.
- CAPTURE, cfg_stop_i without eof: sets stop_pend; the frame completes normally.
- SKIP: cap_en_o=0. On eof -> IDLE if stop_pend | cfg_stop_i, else WAIT_SOF. cfg_stop_i sets stop_pend.
- cfg_start_i while busy is ignored.
- Config inputs are sampled live at the decision cycle; software changes them only while IDLE.
- First frame after start is always eligible: drop_cnt=0 at start.
- ch_rdy_i dropping mid-CAPTURE does not abort the frame; the datapath/uDMA handles overflow.
- Reset mid-frame: immediate return to reset values; no frame_done_o pulse.
- busy_o = (state != IDLE), registered.

Decomposition:
- Shared camera package: state enum cam_seq_state_t (IDLE, WAIT_SOF, CAPTURE, SKIP); default widths for FRAME_CNT_W, NFRAMES_W, DROP_W.
- Single sub-module: camera_edge_det (vsync register plus sof/eof outputs, reset value 1), reused by hsync logic.
- Counters and FSM stay in camera_frame_seq.

Test Plan:
- start, nframes=2, framedrop off, ch_rdy=1, 4 vsync periods -> frame_start_o/frame_done_o twice; frame_cnt_o=2; busy_o falls the cycle after 2nd eof; 3rd sof ignored.
- start, nframes=0, framedrop_en=1, val=2, 9 frames -> frames 1, 4, 7 captured (cap_en_o high only in those); frame_cnt_o=3.
- start with ch_rdy=0 for first 2 SOFs, then 1 -> miss_cnt_o=2; 3rd frame captured, frame_start_o at 3rd sof.
- stop mid-CAPTURE -> cap_en_o held to eof; frame_done_o pulses; IDLE next cycle; stop in WAIT_SOF -> IDLE next cycle, no pulses.
- start and stop same cycle -> busy_o stays 0; start while busy -> frame_cnt_o not cleared.
- rst_i asserted mid-CAPTURE -> all outputs 0 asynchronously; after release, vsync held low causes no spurious sof.
